// File: rtl/div_radix2_pkg.sv
// Shared definitions for the radix-2 restoring divider.
//   div_state_e : FSM state encoding (idle / busy / done)
//   div_cnt_w   : width of the iteration counter for a given operand width
package div_radix2_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StDone = 2'b10
  } div_state_e;

  // Counter must hold the value WIDTH itself.
  function automatic int unsigned div_cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_radix2_step.sv
// One restoring-division iteration (purely combinational).
//   rem_in  : partial remainder before this step
//   q_in    : dividend/quotient shift register; MSB is the next dividend bit
//   divisor : divisor magnitude
//   rem_out : partial remainder after this step
//   q_out   : q_in shifted left with the new quotient bit in the LSB
module div_radix2_step
  import div_radix2_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] q_out
);

  // One extra bit: the shifted remainder can reach 2*divisor-1, and the
  // MSB of the difference is the borrow.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem_in, q_in[WIDTH-1]};
  assign diff    = shifted - {1'b0, divisor};

  always_comb begin
    if (!diff[WIDTH]) begin
      rem_out = diff[WIDTH-1:0];
      q_out   = {q_in[WIDTH-2:0], 1'b1};
    end else begin
      rem_out = shifted[WIDTH-1:0];
      q_out   = {q_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_radix2.sv
// Multi-cycle radix-2 restoring divider (DIV / DIVU) for the execute stage.
//   clk, rst   : clock, synchronous active-high reset
//   start      : divide request; held high while the pipeline is stalled
//   signed_div : 1 = two's complement, 0 = unsigned; sampled on accept
//   annul      : cancel an in-flight operation
//   a, b       : dividend / divisor, sampled on accept
//   ready      : one-cycle pulse, result valid
//   result     : {remainder, quotient}; held until the next completion
module div_radix2
  import div_radix2_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic               annul,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic [2*WIDTH-1:0] result
);

  localparam int unsigned CntW = div_cnt_w(WIDTH);

  div_state_e         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] fix_rem, fix_quo;

  // Plain WIDTH-bit negation: 0x80..0 maps to itself, which is the correct
  // unsigned magnitude, so no sign extension is needed.
  assign a_mag = (signed_div && a[WIDTH-1]) ? -a : a;
  assign b_mag = (signed_div && b[WIDTH-1]) ? -b : b;

  div_radix2_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in (rem_q),
    .q_in   (quo_q),
    .divisor(dvs_q),
    .rem_out(step_rem),
    .q_out  (step_quo)
  );

  assign fix_quo = neg_quo_q ? -step_quo : step_quo;
  assign fix_rem = neg_rem_q ? -step_rem : step_rem;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;

    unique case (state_q)
      StIdle: begin
        if (start && !annul) begin
          rem_d     = '0;
          quo_d     = a_mag;
          dvs_d     = b_mag;
          neg_quo_d = signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d = signed_div & a[WIDTH-1];
          if (b == '0) begin
            // Divide by zero: all-ones quotient, raw dividend as remainder.
            result_d = {a, {WIDTH{1'b1}}};
            state_d  = StDone;
          end else begin
            cnt_d   = CntW'(WIDTH);
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (annul) begin
          state_d = StIdle;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            result_d = {fix_rem, fix_quo};
            state_d  = StDone;
          end
        end
      end
      StDone: begin
        // start is ignored here; the pipeline advances this cycle.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  // An annul arriving in the done cycle suppresses the pulse.
  assign ready  = (state_q == StDone) && !annul;
  assign result = result_q;

endmodule

// File: tb/tb_div_radix2.sv
// Scoreboard bench for div_radix2: the driver pushes the expected result and
// the expected ready cycle; a monitor pops and compares on every ready pulse.
module tb_div_radix2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        signed_div = 1'b0;
  logic        annul = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        ready;
  logic [63:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    string       name;
    logic [63:0] res;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  div_radix2 #(
    .WIDTH(32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_div(signed_div),
    .annul     (annul),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ready pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ready: ready=1 at cycle %0d, expected no pulse", cyc);
      end else begin
        e = sb.pop_front();
        check({e.name, "_result"}, result, e.res);
        check({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // mode 0: hold start until ready, drop after the pulse
  // mode 1: keep start high into the next idle cycle (back-to-back)
  // mode 2: start high for the accept cycle only
  task automatic run_op(input string name, input logic sd, input logic [31:0] av,
                        input logic [31:0] bv, input logic [63:0] exp, input int mode);
    exp_t e;
    int   n;
    signed_div = sd;
    a          = av;
    b          = bv;
    start      = 1'b1;
    e.name = name;
    e.res  = exp;
    e.cyc  = cyc + ((bv == 32'd0) ? 1 : 33);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (mode == 2) start = 1'b0;
    // Operands and mode must already be captured.
    a          = ~av;
    b          = bv ^ 32'h5;
    signed_div = ~sd;
    n = 0;
    while (!ready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: no ready within 40 cycles, expected a pulse", name);
    end
    @(posedge clk);
    #1;
    if (mode != 1) start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_result", result, 64'd0);

    run_op("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 0);
    run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
    run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 0);
    run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 0);
    run_op("divu_big", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0}, 0);
    run_op("div_by0", 1'b1, 32'h1234, 32'd0, {32'h1234, 32'hFFFF_FFFF}, 0);
    run_op("divu_by0", 1'b0, 32'h1234, 32'd0, {32'h1234, 32'hFFFF_FFFF}, 0);

    // Annul mid-operation: no pulse, result untouched.
    signed_div = 1'b0;
    a          = 32'd50;
    b          = 32'd5;
    start      = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    annul = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    annul = 1'b0;
    check("annul_result_held", result, {32'h1234, 32'hFFFF_FFFF});
    run_op("restart_annul", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 0);

    // Reset mid-operation: no pulse, result cleared.
    a     = 32'd50;
    b     = 32'd5;
    start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_result", result, 64'd0);
    run_op("restart_rst", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 0);

    // start together with annul in idle must not be accepted.
    a     = 32'd20;
    b     = 32'd4;
    start = 1'b1;
    annul = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    annul = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("annul_idle_result", result, {32'd0, 32'd3});

    // Back-to-back with start held through the done cycle.
    run_op("b2b_first", 1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 1);
    run_op("b2b_second", 1'b0, 32'hFFFF_FFFF, 32'd16, {32'd15, 32'h0FFF_FFFF}, 0);

    // start dropped while busy: operation still completes.
    run_op("pulse_start", 1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 2);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
